msrv32_pc_seq: RTL and testbench

- Fetch-side next-PC stage of the msrv32 core, directly downstream of the branch unit.
- Consumes the branch unit's taken flag together with the target address from the immediate adder, and selects the next PC from boot, mret/EPC, trap vector or normal flow.
- Holds the architectural PC register and drives the instruction-fetch address.
- Flags misaligned jump targets and raises a one-cycle pipeline flush after any redirect.

---
 rtl/msrv32_pkg.sv | 11 +
 rtl/msrv32_pc_mux.sv | 36 +++
 rtl/msrv32_pc_seq.sv | 71 +++++++
 tb/tb_msrv32_pc_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared msrv32 constants: next-PC source encodings and the default boot vector.
package msrv32_pkg;

    localparam logic [1:0] PC_SRC_BOOT      = 2'b00;
    localparam logic [1:0] PC_SRC_EPC       = 2'b01;
    localparam logic [1:0] PC_SRC_TRAP      = 2'b10;
    localparam logic [1:0] PC_SRC_OPERATING = 2'b11;

    localparam logic [31:0] BOOT_ADDRESS_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/msrv32_pc_mux.sv
// Next-PC select and misaligned-target detection.
// Purely combinational, zero latency; no flow control of its own.
module msrv32_pc_mux
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT
) (
    input  logic [1:0]  pc_src_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic [31:0] pc_plus_4_in,
    output logic [31:0] next_pc_out,
    output logic        misaligned_instr_out
);

    logic [31:0] jump_target;

    // Bit 0 of a jump target is always dropped (JALR semantics).
    assign jump_target = iadder_in & ~32'h0000_0001;

    always_comb begin
        next_pc_out = BOOT_ADDRESS;
        case (pc_src_in)
            PC_SRC_BOOT:      next_pc_out = BOOT_ADDRESS;
            PC_SRC_EPC:       next_pc_out = epc_in;
            PC_SRC_TRAP:      next_pc_out = trap_address_in;
            PC_SRC_OPERATING: next_pc_out = branch_taken_in ? jump_target : pc_plus_4_in;
            default:          next_pc_out = BOOT_ADDRESS;
        endcase
    end

    assign misaligned_instr_out = (pc_src_in == PC_SRC_OPERATING) & branch_taken_in & iadder_in[1];

endmodule

// File: rtl/msrv32_pc_seq.sv
// Architectural PC register, fetch address and post-redirect flush.
// i_addr_out is zero latency; PC/flush update one cycle later; ahb_ready_in = 0 holds all state.
module msrv32_pc_seq
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = BOOT_ADDRESS_DEFAULT
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [1:0]  pc_src_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] trap_address_in,
    input  logic        ahb_ready_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] i_addr_out,
    output logic        misaligned_instr_out,
    output logic        flush_out
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus_4_q, pc_plus_4_d;
    logic        flush_q, flush_d;
    logic [31:0] next_pc;

    msrv32_pc_mux #(
        .BOOT_ADDRESS(BOOT_ADDRESS)
    ) u_pc_mux (
        .pc_src_in            (pc_src_in),
        .branch_taken_in      (branch_taken_in),
        .iadder_in            (iadder_in),
        .epc_in               (epc_in),
        .trap_address_in      (trap_address_in),
        .pc_plus_4_in         (pc_plus_4_q),
        .next_pc_out          (next_pc),
        .misaligned_instr_out (misaligned_instr_out)
    );

    // While in reset the fetch address must point at the boot vector whatever pc_src says.
    assign i_addr_out = ms_riscv32_mp_rst_in ? BOOT_ADDRESS : next_pc;

    always_comb begin
        pc_d        = pc_q;
        pc_plus_4_d = pc_plus_4_q;
        flush_d     = flush_q;
        if (ahb_ready_in) begin
            pc_d        = i_addr_out;
            pc_plus_4_d = i_addr_out + 32'd4;
            flush_d     = (pc_src_in != PC_SRC_OPERATING) | branch_taken_in;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            pc_q        <= BOOT_ADDRESS;
            pc_plus_4_q <= BOOT_ADDRESS + 32'd4;
            flush_q     <= 1'b1;
        end else begin
            pc_q        <= pc_d;
            pc_plus_4_q <= pc_plus_4_d;
            flush_q     <= flush_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_plus_4_out = pc_plus_4_q;
    assign flush_out     = flush_q;

endmodule

// File: tb/tb_msrv32_pc_seq.sv
// Directed-vector bench for msrv32_pc_seq with BOOT_ADDRESS = 32'h1000.
module tb_msrv32_pc_seq;

    localparam logic [31:0] BOOT = 32'h0000_1000;
    localparam logic [1:0]  SRC_BOOT = 2'b00;
    localparam logic [1:0]  SRC_EPC  = 2'b01;
    localparam logic [1:0]  SRC_TRAP = 2'b10;
    localparam logic [1:0]  SRC_OP   = 2'b11;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] iadder;
    logic [31:0] epc;
    logic [31:0] trap_address;
    logic        ahb_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] i_addr;
    logic        misaligned;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    msrv32_pc_seq #(
        .BOOT_ADDRESS(BOOT)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .pc_src_in            (pc_src),
        .branch_taken_in      (branch_taken),
        .iadder_in            (iadder),
        .epc_in               (epc),
        .trap_address_in      (trap_address),
        .ahb_ready_in         (ahb_ready),
        .pc_out               (pc),
        .pc_plus_4_out        (pc_plus_4),
        .i_addr_out           (i_addr),
        .misaligned_instr_out (misaligned),
        .flush_out            (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        pc_src       = SRC_OP;
        branch_taken = 1'b0;
        iadder       = 32'h0;
        epc          = 32'h0;
        trap_address = 32'h0;
        ahb_ready    = 1'b1;

        #2;
        chk("rst_pc",     pc,        BOOT);
        chk("rst_pc4",    pc_plus_4, 32'h1004);
        chk("rst_flush",  {31'b0, flush}, 32'd1);
        chk("rst_iaddr",  i_addr,    BOOT);
        tick();
        tick();
        chk("rst_hold_pc", pc, BOOT);

        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_pc",    pc, 32'h1004);
        chk("post_rst_flush", {31'b0, flush}, 32'd0);

        // Land on 0x200 with flush already cleared.
        pc_src = SRC_EPC;
        epc    = 32'h1FC;
        #1;
        chk("epc_iaddr", i_addr, 32'h1FC);
        tick();
        chk("epc_flush", {31'b0, flush}, 32'd1);
        pc_src = SRC_OP;
        tick();
        chk("seq0_pc",    pc, 32'h200);
        chk("seq0_flush", {31'b0, flush}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc",    pc,        32'h200 + 32'(4 * i));
            chk("seq_pc4",   pc_plus_4, 32'h204 + 32'(4 * i));
            chk("seq_flush", {31'b0, flush}, 32'd0);
        end

        // Aligned taken branch; bit 0 of target cleared.
        branch_taken = 1'b1;
        iadder       = 32'h0000_0101;
        #1;
        chk("br_iaddr", i_addr, 32'h100);
        chk("br_misal", {31'b0, misaligned}, 32'd0);
        tick();
        chk("br_pc",    pc, 32'h100);
        chk("br_flush", {31'b0, flush}, 32'd1);
        branch_taken = 1'b0;
        tick();
        chk("br_after_pc",    pc, 32'h104);
        chk("br_after_flush", {31'b0, flush}, 32'd0);

        // Misaligned target still loads.
        branch_taken = 1'b1;
        iadder       = 32'h102;
        #1;
        chk("mis_flag",  {31'b0, misaligned}, 32'd1);
        chk("mis_iaddr", i_addr, 32'h102);
        tick();
        chk("mis_pc", pc, 32'h102);
        branch_taken = 1'b0;
        #1;
        chk("mis_clear", {31'b0, misaligned}, 32'd0);
        tick();
        chk("mis_after_pc", pc, 32'h106);

        // Stall with a pending branch.
        ahb_ready    = 1'b0;
        branch_taken = 1'b1;
        iadder       = 32'h400;
        #1;
        chk("stall_iaddr", i_addr, 32'h400);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    pc, 32'h106);
            chk("stall_flush", {31'b0, flush}, 32'd0);
        end
        ahb_ready = 1'b1;
        tick();
        chk("unstall_pc",    pc,        32'h400);
        chk("unstall_pc4",   pc_plus_4, 32'h404);
        chk("unstall_flush", {31'b0, flush}, 32'd1);
        branch_taken = 1'b0;
        tick();
        chk("once_pc",    pc, 32'h404);
        chk("once_flush", {31'b0, flush}, 32'd0);

        // Trap beats a simultaneous taken misaligned branch.
        pc_src       = SRC_TRAP;
        trap_address = 32'h8000_0000;
        branch_taken = 1'b1;
        iadder       = 32'h102;
        #1;
        chk("trap_misal", {31'b0, misaligned}, 32'd0);
        chk("trap_iaddr", i_addr, 32'h8000_0000);
        tick();
        chk("trap_pc",    pc, 32'h8000_0000);
        chk("trap_flush", {31'b0, flush}, 32'd1);
        pc_src       = SRC_EPC;
        epc          = 32'h224;
        branch_taken = 1'b0;
        tick();
        chk("mret_pc",    pc, 32'h224);
        chk("mret_flush", {31'b0, flush}, 32'd1);
        pc_src = SRC_OP;
        tick();
        chk("mret_next_pc",    pc, 32'h228);
        chk("mret_next_flush", {31'b0, flush}, 32'd0);

        pc_src = SRC_BOOT;
        tick();
        chk("boot_pc",    pc, BOOT);
        chk("boot_flush", {31'b0, flush}, 32'd1);

        // Wrap-around at the top of the address space.
        pc_src = SRC_EPC;
        epc    = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pre_pc4", pc_plus_4, 32'h0);
        pc_src = SRC_OP;
        tick();
        chk("wrap_pc",    pc,        32'h0);
        chk("wrap_pc4",   pc_plus_4, 32'h4);
        chk("wrap_flush", {31'b0, flush}, 32'd0);

        // Async reset between edges, with a non-OPERATING source selected.
        pc_src = SRC_EPC;
        epc    = 32'h0000_5550;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc",    pc,        BOOT);
        chk("arst_pc4",   pc_plus_4, 32'h1004);
        chk("arst_flush", {31'b0, flush}, 32'd1);
        chk("arst_iaddr", i_addr,    BOOT);
        @(negedge clk);
        rst    = 1'b0;
        pc_src = SRC_OP;
        tick();
        chk("arst_release_pc", pc, 32'h1004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
